// File: rtl/line_scan_ctrl_pkg.sv
// Shared game definitions for the playfield line sequencer and row storage.
package line_scan_ctrl_pkg;

  // Default playfield geometry, shared with the row storage
  localparam int LSC_NUM_LINES = 8;
  localparam int LSC_COLS      = 8;

  // Scan direction encoding as seen on mode_dir
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/line_scan_ctrl_step_counter.sv
// Loadable up/down line index counter with a last-line flag for the scan direction.
module line_step_counter
  import line_scan_ctrl_pkg::*;
#(
  parameter int LINE_W    = 3,
  parameter int NUM_LINES = LSC_NUM_LINES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_val,
  input  logic              step,
  input  logic              dir,
  output logic [LINE_W-1:0] count,
  output logic              is_last
);

  logic [LINE_W-1:0] count_d;
  logic [LINE_W-1:0] count_q;

  // Load has priority over stepping; step direction follows dir
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      count_d = (dir == DIR_DOWN) ? count_q - LINE_W'(1) : count_q + LINE_W'(1);
    end
  end

  // Index register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count   = count_q;
  assign is_last = (dir == DIR_DOWN) ? (count_q == '0)
                                     : (count_q == LINE_W'(NUM_LINES - 1));

endmodule

// File: rtl/line_scan_ctrl.sv
// Playfield line sequencer: walks line indices, records full rows into a mask and count.
module line_scan_ctrl
  import line_scan_ctrl_pkg::*;
#(
  parameter int NUM_LINES = LSC_NUM_LINES,
  parameter int LINE_W    = 3,
  parameter int COLS      = LSC_COLS,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode_dir,
  input  logic                 continuous,
  input  logic [COLS-1:0]      row_data,
  input  logic                 row_valid,
  output logic                 enable,
  output logic [LINE_W-1:0]    line_num,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_LINES-1:0] full_mask,
  output logic [CNT_W-1:0]     full_count
);

  // Parameter sanity: enough index bits, and the full count can never wrap
  if (NUM_LINES < 2) begin : g_chk_lines
    $error("line_scan_ctrl: NUM_LINES must be at least 2");
  end
  if ((2 ** LINE_W) < NUM_LINES) begin : g_chk_line_w
    $error("line_scan_ctrl: LINE_W too narrow for NUM_LINES");
  end
  if ((2 ** CNT_W) <= NUM_LINES) begin : g_chk_cnt_w
    $error("line_scan_ctrl: CNT_W too narrow, full_count could wrap");
  end

  scan_state_e          state_d, state_q;
  logic                 dir_d, dir_q;
  logic [NUM_LINES-1:0] full_mask_d, full_mask_q;
  logic [CNT_W-1:0]     full_count_d, full_count_q;
  logic                 enable_d, enable_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;

  logic                 cnt_load;
  logic [LINE_W-1:0]    cnt_load_val;
  logic                 cnt_step;
  logic                 cnt_is_last;
  logic                 row_full;

  line_step_counter #(
    .LINE_W   (LINE_W),
    .NUM_LINES(NUM_LINES)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .step    (cnt_step),
    .dir     (dir_q),
    .count   (line_num),
    .is_last (cnt_is_last)
  );

  assign row_full = &row_data;

  // Next-state, re-arm and row accounting; status outputs decoded from next state
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    full_mask_d  = full_mask_q;
    full_count_d = full_count_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // start wins over any row_valid seen while idle
        if (start) begin
          state_d      = ST_SCAN;
          dir_d        = mode_dir;
          full_mask_d  = '0;
          full_count_d = '0;
          cnt_load     = 1'b1;
          cnt_load_val = (mode_dir == DIR_DOWN) ? LINE_W'(NUM_LINES - 1) : '0;
        end
      end
      ST_SCAN: begin
        if (row_valid) begin
          for (int i = 0; i < NUM_LINES; i++) begin
            if (line_num == LINE_W'(i)) full_mask_d[i] = row_full;
          end
          full_count_d = full_count_q + {{(CNT_W - 1){1'b0}}, row_full};
          if (cnt_is_last) state_d  = ST_DONE;
          else             cnt_step = 1'b1;
        end
      end
      ST_DONE: begin
        if (continuous) begin
          state_d      = ST_SCAN;
          full_mask_d  = '0;
          full_count_d = '0;
          cnt_load     = 1'b1;
          cnt_load_val = (dir_q == DIR_DOWN) ? LINE_W'(NUM_LINES - 1) : '0;
        end else begin
          state_d      = ST_IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    enable_d = (state_d == ST_SCAN);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      full_mask_q  <= '0;
      full_count_q <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      full_mask_q  <= full_mask_d;
      full_count_q <= full_count_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign enable     = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full_mask  = full_mask_q;
  assign full_count = full_count_q;

endmodule

// File: tb/tb_line_scan_ctrl.sv
// Directed bench for line_scan_ctrl: default 8-line build plus a 20-line build.
module tb_line_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode_dir, continuous, row_valid;
  logic [7:0]  row_data;
  logic        enable, busy, done;
  logic [2:0]  line_num;
  logic [7:0]  full_mask;
  logic [3:0]  full_count;

  logic        start2, mode_dir2, continuous2, row_valid2;
  logic [9:0]  row_data2;
  logic        enable2, busy2, done2;
  logic [4:0]  line_num2;
  logic [19:0] full_mask2;
  logic [4:0]  full_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  line_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode_dir(mode_dir),
    .continuous(continuous), .row_data(row_data), .row_valid(row_valid),
    .enable(enable), .line_num(line_num), .busy(busy), .done(done),
    .full_mask(full_mask), .full_count(full_count)
  );

  line_scan_ctrl #(.NUM_LINES(20), .LINE_W(5), .COLS(10), .CNT_W(5)) dut20 (
    .clk(clk), .rst(rst), .start(start2), .mode_dir(mode_dir2),
    .continuous(continuous2), .row_data(row_data2), .row_valid(row_valid2),
    .enable(enable2), .line_num(line_num2), .busy(busy2), .done(done2),
    .full_mask(full_mask2), .full_count(full_count2)
  );

  typedef struct {
    logic       rst, start, dir, cont, rv;
    logic [7:0] data;
    logic       en;
    logic [2:0] line;
    logic       busy, done;
    logic [7:0] mask;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic en, input logic [2:0] ln,
                           input logic bz, input logic dn, input logic [7:0] m,
                           input logic [3:0] c);
    check({tag, ".enable"}, 32'(enable), 32'(en));
    check({tag, ".line_num"}, 32'(line_num), 32'(ln));
    check({tag, ".busy"}, 32'(busy), 32'(bz));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".full_mask"}, 32'(full_mask), 32'(m));
    check({tag, ".full_count"}, 32'(full_count), 32'(c));
  endtask

  initial begin
    //          rst start dir cont rv data    en line busy done mask   cnt
    tbl[0]  = '{0, 1, 0, 0, 0, 8'h00, 1, 3'd0, 1, 0, 8'h00, 4'd0};
    tbl[1]  = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd1, 1, 0, 8'h00, 4'd0};
    tbl[2]  = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd2, 1, 0, 8'h00, 4'd0};
    tbl[3]  = '{0, 0, 0, 0, 1, 8'hFF, 1, 3'd3, 1, 0, 8'h04, 4'd1};
    tbl[4]  = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd4, 1, 0, 8'h04, 4'd1};
    tbl[5]  = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd5, 1, 0, 8'h04, 4'd1};
    tbl[6]  = '{0, 0, 0, 0, 1, 8'hFF, 1, 3'd6, 1, 0, 8'h24, 4'd2};
    tbl[7]  = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd7, 1, 0, 8'h24, 4'd2};
    tbl[8]  = '{0, 0, 0, 0, 1, 8'hF7, 0, 3'd7, 1, 1, 8'h24, 4'd2};
    tbl[9]  = '{0, 0, 0, 0, 0, 8'h00, 0, 3'd0, 0, 0, 8'h24, 4'd2};
    tbl[10] = '{0, 0, 0, 0, 1, 8'hFF, 0, 3'd0, 0, 0, 8'h24, 4'd2};
    tbl[11] = '{0, 1, 0, 0, 1, 8'hFF, 1, 3'd0, 1, 0, 8'h00, 4'd0};
    tbl[12] = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd1, 1, 0, 8'h00, 4'd0};
    tbl[13] = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd2, 1, 0, 8'h00, 4'd0};
    tbl[14] = '{0, 0, 0, 0, 1, 8'hF7, 1, 3'd3, 1, 0, 8'h00, 4'd0};
    tbl[15] = '{1, 0, 0, 0, 1, 8'hFF, 0, 3'd0, 0, 0, 8'h00, 4'd0};
    tbl[16] = '{1, 0, 0, 0, 1, 8'hFF, 0, 3'd0, 0, 0, 8'h00, 4'd0};
    tbl[17] = '{0, 0, 0, 0, 1, 8'hFF, 0, 3'd0, 0, 0, 8'h00, 4'd0};
    tbl[18] = '{0, 0, 0, 0, 1, 8'hFF, 0, 3'd0, 0, 0, 8'h00, 4'd0};

    rst = 1'b1; start = 0; mode_dir = 0; continuous = 0; row_valid = 0; row_data = '0;
    start2 = 0; mode_dir2 = 0; continuous2 = 0; row_valid2 = 0; row_data2 = '0;
    #1;
    tick();
    tick();
    check_all("reset", 0, 3'd0, 0, 0, 8'h00, 4'd0);
    rst = 1'b0;
    tick();

    // Up scan back-to-back, idle row_valid, start+row_valid, mid-scan reset
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; mode_dir = tbl[i].dir;
      continuous = tbl[i].cont; row_valid = tbl[i].rv; row_data = tbl[i].data;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].line, tbl[i].busy,
                tbl[i].done, tbl[i].mask, tbl[i].cnt);
    end
    rst = 0; start = 0; row_valid = 0;

    // Down scan with one stall cycle per line; mode_dir flips mid-scan
    start = 1; mode_dir = 1;
    tick();
    check("down.first_line", 32'(line_num), 32'd7);
    start = 0; mode_dir = 0;
    for (int l = 7; l >= 0; l--) begin
      row_valid = 0; row_data = 8'hFF;
      tick();
      check($sformatf("down.stall%0d", l), 32'({enable, line_num, done}), 32'({1'b1, 3'(l), 1'b0}));
      row_valid = 1; row_data = (l == 7 || l == 0) ? 8'hFF : 8'h7F;
      tick();
      if (l > 0) check($sformatf("down.step%0d", l), 32'(line_num), 32'(l - 1));
    end
    check_all("down.done", 0, 3'd0, 1, 1, 8'h81, 4'd2);
    row_valid = 0;
    tick();
    check("down.after_done", 32'({done, busy}), 32'd0);
    tick();
    check("down.single_done", 32'(done), 32'd0);

    // Continuous re-arm with all rows full
    start = 1; mode_dir = 0; continuous = 1;
    tick();
    check("cont.cleared", 32'({full_mask, full_count}), 32'd0);
    start = 0;
    row_valid = 1; row_data = 8'hFF;
    for (int l = 0; l < 8; l++) tick();
    row_valid = 0;
    check_all("cont.done1", 0, 3'd7, 1, 1, 8'hFF, 4'd8);
    tick();
    check_all("cont.rearm", 1, 3'd0, 1, 0, 8'h00, 4'd0);
    row_valid = 1;
    for (int l = 0; l < 8; l++) tick();
    row_valid = 0; continuous = 0;
    check_all("cont.done2", 0, 3'd7, 1, 1, 8'hFF, 4'd8);
    tick();
    check_all("cont.idle", 0, 3'd0, 0, 0, 8'hFF, 4'd8);

    // start while busy: mid-scan and in the DONE cycle
    start = 1; mode_dir = 0;
    tick();
    start = 0; row_valid = 1; row_data = 8'h00;
    for (int l = 0; l < 4; l++) tick();
    check("busy.at4", 32'(line_num), 32'd4);
    start = 1;
    tick();
    check("busy.ignored_mid", 32'({enable, line_num}), 32'({1'b1, 3'd5}));
    start = 0;
    for (int l = 5; l < 8; l++) tick();
    check_all("busy.done", 0, 3'd7, 1, 1, 8'h00, 4'd0);
    start = 1; row_valid = 0;
    tick();
    check_all("busy.idle", 0, 3'd0, 0, 0, 8'h00, 4'd0);
    start = 0;
    tick();
    check("busy.stay_idle", 32'({enable, busy, done}), 32'd0);

    // 20-line build, down scan
    start2 = 1; mode_dir2 = 1;
    tick();
    start2 = 0;
    for (int l = 19; l >= 0; l--) begin
      check($sformatf("p20.line%0d", l), 32'({enable2, line_num2}), 32'({1'b1, 5'(l)}));
      row_valid2 = 1; row_data2 = (l == 19 || l == 0) ? 10'h3FF : 10'h2FF;
      tick();
    end
    row_valid2 = 0;
    check("p20.done", 32'({done2, busy2}), 32'b11);
    check("p20.mask", 32'(full_mask2), 32'h80001);
    check("p20.count", 32'(full_count2), 32'd2);
    tick();
    check("p20.idle", 32'({busy2, done2}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_scan_ctrl.md
Name: line_scan_ctrl

Overview:
Parametrised playfield line sequencer for the game logic. On a start request it walks line indices over NUM_LINES rows, up or down, one line per accepted row handshake. For each row it records whether the row is full, giving a per-line full mask and a full-line count for the line-clear logic. It can run single-shot or re-arm continuously, and sits between the game FSM and the playfield row storage.

Parameters:
NUM_LINES, 8, number of playfield lines scanned (>=2)
LINE_W, 3, width of line index; must satisfy 2**LINE_W >= NUM_LINES
COLS, 8, row width in cells
CNT_W, 4, full-count width; must satisfy 2**CNT_W > NUM_LINES

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  scan request pulse; accepted only when busy=0
mode_dir  in  1  0: scan line 0 up to NUM_LINES-1; 1: NUM_LINES-1 down to 0; latched at accepted start
continuous  in  1  sampled in DONE; 1 re-arms a new scan immediately
row_data  in  COLS  cell bits of line line_num; 1 = occupied
row_valid  in  1  row_data valid for current line_num; acts as ack
enable  out  1  row request; high in SCAN only
line_num  out  LINE_W  line currently requested
busy  out  1  high in SCAN and DONE
done  out  1  one-cycle pulse at scan completion
full_mask  out  NUM_LINES  bit i = line i was all-ones in the current/last scan
full_count  out  CNT_W  number of set bits in full_mask

Behaviour:
- One clock, one synchronous active-high reset. rst=1 at any clock edge, including mid-scan, forces state IDLE and all outputs to 0: enable, line_num, busy, done, full_mask, full_count. Any in-flight scan is discarded.
- States: IDLE, SCAN, DONE.
- IDLE: enable=0, busy=0, line_num=0.
  - full_mask/full_count keep the last scan's results.
  - start=1 -> SCAN next cycle. That edge latches mode_dir, clears full_mask/full_count, and loads line_num with the first line (0 or NUM_LINES-1).
  - row_valid is ignored in IDLE.
- SCAN: enable=1, busy=1.
  - Latency: start at cycle N -> enable=1 and line_num=first at N+1.
  - row_valid=1 at cycle M: full_mask[line_num] <= &row_data, and full_count increments if full. Both are visible at M+1.
  - Not last line: line_num steps +1 (up) or -1 (down) at M+1.
  - Last line (NUM_LINES-1 up, 0 down): state goes to DONE at M+1, and line_num holds.
  - row_valid may be high on consecutive cycles, giving one line per cycle. row_valid=0 stalls with line_num held, with no timeout.
- DONE: enable=0, busy=1, done=1 for exactly this one cycle. full_mask/full_count are final.
  - continuous=1 -> SCAN next cycle with the same re-arm actions as start, using the previously latched mode_dir.
  - continuous=0 -> IDLE next cycle; line_num returns to 0 on entry to IDLE.
- start while busy=1, including in DONE, is ignored with no queueing. start together with row_valid in IDLE: start wins, and row_valid is dropped.
- A mode_dir change mid-scan has no effect.
- full_count never wraps: maximum NUM_LINES < 2**CNT_W, guaranteed by the parameter constraint. Check it with an elaboration-time assertion.
- Minimum scan time from start to done pulse: NUM_LINES+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared game package holds:
  - the state enum (IDLE/SCAN/DONE)
  - direction constants DIR_UP=0 and DIR_DOWN=1
  - default NUM_LINES/COLS shared with the playfield storage.
- One sub-module, line_step_counter: a loadable up/down counter, parametrised on LINE_W/NUM_LINES.
  - Inputs: load, load_val, step, dir.
  - Outputs: count, is_last.
- The FSM, mask and count logic stay in line_scan_ctrl.

Test Plan:
- Reset/idle: rst=1 for 2 cycles mid-scan (line_num=3) -> next cycle all outputs 0, state IDLE; row_valid pulses afterward leave full_mask=0.
- Up scan, back-to-back: mode_dir=0, start, row_valid=1 every cycle; rows 2 and 5 = 8'hFF, others 8'hF7 -> line_num 0..7 on consecutive cycles, done pulse at start+9, full_mask=8'b0010_0100, full_count=2, busy=0 at start+10.
- Down scan with stalls: mode_dir=1, row_valid toggling 1,0; row 7 = 8'hFF and row 0 = 8'hFF -> line_num 7,6,...,0, each held during stall cycles; full_mask=8'h81, full_count=2; single done pulse.
- Continuous re-arm: continuous=1, all rows full -> done pulses, next cycle enable=1 and line_num=0; full_mask cleared to 0 and then refilled; second done shows full_count=8 (no wrap with CNT_W=4).
- Start while busy: start pulses at line_num=4 and in the DONE cycle (continuous=0) -> scan continues unaffected; exactly one done; IDLE afterward.
- Parametrised build: NUM_LINES=20, LINE_W=5, COLS=10, CNT_W=5, rows 0 and 19 full, mode_dir=1 -> line_num 19..0, full_mask=20'h80001, full_count=2.
